// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin APB master sharing one completer among NUM_REQ requesters
module apb_rr_master #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_accept,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [WIDTH-1:0]              pwdata,
  input  logic [WIDTH-1:0]              prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         grant_q, grant_d;
  logic [IDXW-1:0]         last_q, last_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [WIDTH-1:0]        pwdata_q, pwdata_d;
  logic [7:0]              wait_q, wait_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]        wdata_arr [NUM_REQ];
  logic [IDXW-1:0]         win;
  logic [IDXW-1:0]         cand;
  logic                    found;
  logic                    timeout_hit;
  logic [NUM_REQ-1:0]      grant_oh;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
  end

  assign grant_oh    = NUM_REQ'(1) << grant_q;
  assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));

  // Round-robin search starting just above the previous winner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: pready takes priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (found) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the state.
  always_comb begin
    psel       = (state_q != ST_IDLE);
    penable    = (state_q == ST_ACCESS);
    busy       = (state_q != ST_IDLE);
    req_accept = (state_q == ST_SETUP) ? grant_oh : '0;
  end

  // Datapath next-state: command latch at grant, wait counting, response capture.
  always_comb begin
    grant_d     = grant_q;
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    wait_d      = wait_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d  = win;
          last_d   = win;
          paddr_d  = addr_arr[win];
          pwrite_d = req_write[win];
          pwdata_d = wdata_arr[win];
        end
      end
      ST_SETUP: begin
        wait_d = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = grant_oh;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          wait_d      = '0;
        end else if (timeout_hit) begin
          rsp_valid_d = grant_oh;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          wait_d      = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; last starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge pclk) begin
    if (preset) begin
      grant_q     <= '0;
      last_q      <= IDXW'(NUM_REQ - 1);
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      wait_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB completer, such as the 256-word memory slave, between `NUM_REQ` local requesters. Each requester issues single read/write commands over a simple request/accept interface. The block arbitrates between them, drives the APB SETUP/ACCESS sequence, absorbs completer wait states and aborts transfers whose `pready` never arrives. It sits between the bus-client logic and the APB completer port.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: data width.
- `ADDR_WIDTH`, 8: address width.
- `TIMEOUT`, 15: maximum ACCESS cycles without `pready` before abort, 1..255.

Ports:
- `pclk`  in  1: the single clock; everything is sampled on its rising edge.
- `preset`  in  1: synchronous reset, active-high.
- `req_valid`  in  NUM_REQ: per-requester command pending; held high until accepted.
- `req_write`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*WIDTH: packed write data, sliced the same way.
- `req_accept`  out  NUM_REQ: one-hot, one-cycle pulse when a command is taken.
- `rsp_valid`  out  NUM_REQ: one-hot, one-cycle pulse when the command completes.
- `rsp_rdata`  out  WIDTH: read data; valid with `rsp_valid`.
- `rsp_err`  out  1: completer error or timeout; valid with `rsp_valid`.
- `busy`  out  1: high in SETUP and ACCESS.
- `psel`, `penable`, `pwrite`  out  1: APB control.
- `paddr`  out  ADDR_WIDTH: APB address.
- `pwdata`  out  WIDTH: APB write data.
- `prdata`  in  WIDTH: APB read data.
- `pready`  in  1: APB ready.
- `pslverr`  in  1: APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- **IDLE:** if any `req_valid` bit is high:
  - Pick a winner g by round-robin, searching upward from `last+1` modulo `NUM_REQ`.
  - Latch the winner's write, addr and wdata into `paddr`/`pwrite`/`pwdata`.
  - Set `last` to g and go to SETUP.
  - With no requests, stay in IDLE.
- **SETUP:** `psel`=1, `penable`=0, `req_accept[g]`=1. Always go to ACCESS. `req_valid` is ignored here.
- **ACCESS:** `psel`=1, `penable`=1. A wait counter starts at 0 and increments every ACCESS cycle with `pready`=0.
  - If `pready`=1: register `rsp_rdata` = `prdata` for reads and 0 for writes; register `rsp_err` = `pslverr`; pulse `rsp_valid[g]` next cycle; go to IDLE.
  - Else if the counter equals `TIMEOUT`-1: abort. Set `rsp_err`=1, `rsp_rdata`=0, pulse `rsp_valid[g]` next cycle, go to IDLE.
- `paddr`, `pwrite` and `pwdata` stay stable from the SETUP cycle through the last ACCESS cycle, and hold their value in IDLE.
- `rsp_rdata` and `rsp_err` hold their value between pulses.
- Only one requester is granted at a time. The grant is never preempted.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite`, `busy` = 0.
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
  - `rsp_err`, `req_accept`, `rsp_valid` = 0.
  - `last` = `NUM_REQ`-1, so requester 0 wins first.
  - Wait counter = 0.
- Timing for the command pending in IDLE cycle n (SETUP is cycle n+1):

  | Event | Cycle |
  |---|---|
  | SETUP | n+1 |
  | First ACCESS | n+2 |
  | `rsp_valid` (`pready` in first ACCESS) | n+3 |
  | `rsp_valid` (k wait cycles) | n+3+k |

- The `rsp_valid` cycle is an IDLE cycle and may pick the next grant. Minimum cost is 3 cycles per transfer.
- `req_accept` precedes `rsp_valid` by at least 2 cycles. A requester may present its next command after `req_accept`. It is considered only in a later IDLE.
- If `pready` and timeout expiry happen in the same cycle, `pready` wins: normal completion with `rsp_err` = `pslverr`.
- `preset` during SETUP or ACCESS: the next edge returns everything to reset values. `psel` drops, and no `rsp_valid` is produced for the aborted transfer.
- `req_valid` deasserted before acceptance is a protocol violation. The latched command still completes.
- Only one of `req_accept` and `rsp_valid` has any bit set in a given cycle.

## Test plan
1. **Single write then read.** Req0 writes 0xDEADBEEF to 0x10, then reads 0x10, against the memory slave (`pready` on the 2nd ACCESS cycle).
   - Each transfer: SETUP 1 cycle, ACCESS 2 cycles.
   - Read returns `rsp_rdata`=0xDEADBEEF with `rsp_err`=0.
   - `rsp_valid[0]` arrives 4 cycles after each IDLE grant.
2. **Round-robin fairness.** All 4 requesters held valid continuously for 12 transfers.
   - Grant order is 0,1,2,3,0,1,2,3,…
   - With zero-wait `pready`, a new SETUP starts every 3 cycles.
3. **Timeout.** `pready` tied 0, `TIMEOUT`=15.
   - Exactly 15 ACCESS cycles occur.
   - Then `rsp_valid` pulses with `rsp_err`=1, `rsp_rdata`=0, and `psel` returns to 0.
4. **Slave error.** Completer returns `pslverr`=1 with `pready` on a read of 0x20.
   - `rsp_err`=1, and `rsp_rdata` equals the `prdata` sampled.
5. **Mid-transfer reset.** `preset` asserted in the first ACCESS cycle of req2.
   - Next cycle: `psel`=`penable`=0 and no `rsp_valid`.
   - After release, req0 is granted first when all requesters are pending.
6. **Simultaneous `pready` and timeout.** `pready` rises exactly in ACCESS cycle `TIMEOUT`.
   - Completion is normal, with `rsp_err` = `pslverr` = 0.
